freq_meter: RTL

Measures the frequency of an external digital signal by counting its rising edges over a fixed gate window of system-clock cycles, then presenting the count with a one-cycle valid strobe. It is the measuring counterpart of the team's clock divider: it reads divided or external clocks back into the design for display or self-check logic. It supports single-shot and continuous (back-to-back, no dead cycle) measurement.

---
 rtl/freq_meter.sv | 138 +++++++++++++
 1 files changed

// File: rtl/freq_meter.sv
// freq_meter: counts rising edges of sig_i over a window of GATE_CYCLES clk_i cycles.
// Define FREQ_METER_SYNC_EN to put a 2-flop synchronizer in front of the edge detector.
module freq_meter #(
   parameter int GATE_CYCLES = 50_000_000,
   parameter int CNT_W       = 26
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             sig_i,
   input  logic             start_i,
   input  logic             cont_i,
   output logic [CNT_W-1:0] freq_o,
   output logic             valid_o,
   output logic             busy_o,
   output logic             ovf_o
);

   localparam int                GATE_W    = $clog2(GATE_CYCLES);
   localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
   localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

   typedef enum logic {
      IDLE,
      COUNT
   } state_t;

   state_t            state_q;
   logic [GATE_W-1:0] gateCnt_q;
   logic [CNT_W-1:0]  edgeCnt_q;
   logic [CNT_W-1:0]  edgeCnt_d;
   logic              ovfRun_q;
   logic [CNT_W-1:0]  freq_q;
   logic              valid_q;
   logic              busy_q;
   logic              ovf_q;
   logic              sigSync_q;
   logic              sigDly_q;
   logic              edgeDet;
   logic              edgeSat;

`ifdef FREQ_METER_SYNC_EN
   logic sigMeta_q;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         sigMeta_q <= 1'b0;
         sigSync_q <= 1'b0;
      end else begin
         sigMeta_q <= sig_i;
         sigSync_q <= sigMeta_q;
      end
   end
`else
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         sigSync_q <= 1'b0;
      end else begin
         sigSync_q <= sig_i;
      end
   end
`endif

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         sigDly_q <= 1'b0;
      end else begin
         sigDly_q <= sigSync_q;
      end
   end

   assign edgeDet = sigSync_q & ~sigDly_q;

   // Saturating count including this cycle's edge; shared by mid-window and terminal cycles.
   always_comb begin
      edgeSat   = edgeDet && (edgeCnt_q == CNT_MAX);
      edgeCnt_d = edgeCnt_q;
      if (edgeDet && !edgeSat) begin
         edgeCnt_d = edgeCnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q   <= IDLE;
         gateCnt_q <= '0;
         edgeCnt_q <= '0;
         ovfRun_q  <= 1'b0;
         freq_q    <= '0;
         valid_q   <= 1'b0;
         busy_q    <= 1'b0;
         ovf_q     <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         case (state_q)
            IDLE: begin
               gateCnt_q <= '0;
               edgeCnt_q <= '0;
               ovfRun_q  <= 1'b0;
               if (start_i || cont_i) begin
                  state_q <= COUNT;
                  busy_q  <= 1'b1;
               end
            end
            COUNT: begin
               if (gateCnt_q == GATE_LAST) begin
                  // The terminal cycle's edge belongs to the ending window; the next cycle is gate 0.
                  freq_q    <= edgeCnt_d;
                  ovf_q     <= ovfRun_q | edgeSat;
                  valid_q   <= 1'b1;
                  gateCnt_q <= '0;
                  edgeCnt_q <= '0;
                  ovfRun_q  <= 1'b0;
                  if (!cont_i) begin
                     state_q <= IDLE;
                     busy_q  <= 1'b0;
                  end
               end else begin
                  gateCnt_q <= gateCnt_q + GATE_W'(1);
                  edgeCnt_q <= edgeCnt_d;
                  if (edgeSat) begin
                     ovfRun_q <= 1'b1;
                  end
               end
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign freq_o  = freq_q;
   assign valid_o = valid_q;
   assign busy_o  = busy_q;
   assign ovf_o   = ovf_q;

endmodule
